quickq_req_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one QuickQ core (control FSM, value router, BRAM) among NREQ independent requesters. Accepts one enqueue/dequeue request at a time and pre-checks full/empty. Issues a single-cycle enq/deq pulse to the core, waits for completion under a watchdog, and returns a tagged response. Sits between client logic and the QuickQ core wrapper.

---
 rtl/quickq_pkg.sv | 24 ++
 rtl/quickq_req_arbiter_rr.sv | 29 ++
 rtl/quickq_req_arbiter.sv | 137 +++++++++++++
 tb/tb_quickq_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quickq_pkg.sv
// Shared types for the QuickQ request arbiter: operation codes, response
// status codes and the sequencer state encoding.
package quickq_pkg;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FULL    = 2'd1,
    ST_EMPTY   = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/quickq_req_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping modulo NREQ, returned both one-hot and encoded.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grant_idx_o,
  output logic                    grant_vld_o
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    // Scan farthest-first so the requester nearest rr_ptr is the last writer.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(rr_ptr_i) + k) % NREQ]) begin
        grant_idx_o = IW'((int'(rr_ptr_i) + k) % NREQ);
        grant_vld_o = 1'b1;
      end
    end
    if (grant_vld_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/quickq_req_arbiter.sv
// Shares one QuickQ core among NREQ requesters: round-robin grant, full/empty
// pre-check, single-cycle core pulse, watchdog-bounded wait, tagged response.
module quickq_req_arbiter
  import quickq_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*W-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_data,
  output logic [1:0]              rsp_status,
  output logic                    core_enq,
  output logic                    core_deq,
  output logic [W-1:0]            core_wdata,
  input  logic                    core_done,
  input  logic [W-1:0]            core_rdata,
  input  logic                    core_full,
  input  logic                    core_empty
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_e      state_q;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   id_q;
  op_e             op_q;
  logic [CW-1:0]   wd_cnt_q;
  logic            core_enq_q, core_deq_q;
  logic [W-1:0]    core_wdata_q;
  logic            rsp_valid_q;
  logic [IW-1:0]   rsp_id_q;
  logic [W-1:0]    rsp_data_q;
  status_e         rsp_status_q;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_vld;
  op_e             gnt_op;
  logic [W-1:0]    gnt_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign gnt_op   = op_e'(req_op[grant_idx]);
  assign gnt_data = req_data[int'(grant_idx)*W +: W];
  assign rr_ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

  // The accept pulse must coincide with the IDLE cycle that samples the request.
  assign req_ready = (state_q == IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_q         <= OP_ENQ;
      wd_cnt_q     <= '0;
      core_enq_q   <= 1'b0;
      core_deq_q   <= 1'b0;
      core_wdata_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      core_enq_q  <= 1'b0;
      core_deq_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            id_q     <= grant_idx;
            op_q     <= gnt_op;
            rr_ptr_q <= rr_ptr_d;
            if ((gnt_op == OP_ENQ && core_full) || (gnt_op == OP_DEQ && core_empty)) begin
              rsp_valid_q  <= 1'b1;
              rsp_id_q     <= grant_idx;
              rsp_data_q   <= '0;
              rsp_status_q <= (gnt_op == OP_ENQ) ? ST_FULL : ST_EMPTY;
              state_q      <= RESP;
            end else begin
              core_enq_q   <= (gnt_op == OP_ENQ);
              core_deq_q   <= (gnt_op == OP_DEQ);
              core_wdata_q <= (gnt_op == OP_ENQ) ? gnt_data : '0;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_cnt_q <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (wd_cnt_q != '1) wd_cnt_q <= wd_cnt_q + 1'b1;
          if (core_done) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_data_q   <= (op_q == OP_DEQ) ? core_rdata : '0;
            rsp_status_q <= ST_OK;
            state_q      <= RESP;
          end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_TIMEOUT;
            state_q      <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_enq   = core_enq_q;
  assign core_deq   = core_deq_q;
  assign core_wdata = core_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_quickq_req_arbiter.sv
// Bench for quickq_req_arbiter: table of single transactions plus hand-written
// round-robin, timeout and mid-operation reset sequences, checked by a scoreboard.
module tb_quickq_req_arbiter;
  import quickq_pkg::*;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic [1:0]        rsp_status;
  logic              core_enq, core_deq;
  logic [W-1:0]      core_wdata;
  logic              core_done;
  logic [W-1:0]      core_rdata;
  logic              core_full, core_empty;

  always #5 clk = ~clk;

  quickq_req_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .core_enq   (core_enq),
    .core_deq   (core_deq),
    .core_wdata (core_wdata),
    .core_done  (core_done),
    .core_rdata (core_rdata),
    .core_full  (core_full),
    .core_empty (core_empty)
  );

  typedef struct {
    logic [1:0]  id;
    logic [1:0]  status;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [1:0]  id;
    logic        op;
    logic [31:0] data;
    logic        full;
    logic        empty;
    int          k;
    logic [31:0] rdata;
    logic [1:0]  status;
  } vec_t;

  rsp_t        exp_q[$];
  logic [31:0] core_vals[$];
  int          n_chk = 0;
  int          n_fail = 0;

  logic [NREQ-1:0] ob_ready;
  logic            ob_enq, ob_deq, ob_rsp;
  logic [31:0]     ob_wdata;

  bit auto_core = 1'b0;
  bit cd_armed  = 1'b0;
  int cd_delay  = 0;
  int cur_k     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    rsp_t e;
    ob_ready = req_ready;
    ob_enq   = core_enq;
    ob_deq   = core_deq;
    ob_wdata = core_wdata;
    ob_rsp   = rsp_valid;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", rsp_data, e.data);
        check("rsp_status", 32'(rsp_status), 32'(e.status));
      end
    end
    if (auto_core && (core_enq || core_deq)) begin
      cd_armed = 1'b1;
      cd_delay = cur_k + 1;
    end
  endtask

  // Samples the current cycle at the falling edge, then moves 1ns past the
  // next rising edge where the core model and the caller drive new inputs.
  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    core_done = 1'b0;
    if (cd_armed) begin
      cd_delay--;
      if (cd_delay == 0) begin
        cd_armed   = 1'b0;
        core_done  = 1'b1;
        core_rdata = (core_vals.size() != 0) ? core_vals.pop_front() : 32'hBAD0_BAD0;
      end
    end
  endtask

  task automatic wait_grant(input string name, output bit found);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      cyc();
      if (ob_ready != '0) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    bit found, got, accepted;
    int lat, enqs, deqs, pulse_c;
    logic [31:0] wd;
    rsp_t e;
    accepted  = !((v.op == 1'b0 && v.full) || (v.op == 1'b1 && v.empty));
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_op[v.id]    = v.op;
    req_data[int'(v.id)*W +: W] = v.data;
    core_full  = v.full;
    core_empty = v.empty;
    cur_k      = v.k;
    auto_core  = 1'b1;
    if (accepted) core_vals.push_back((v.op == 1'b1) ? v.rdata : 32'hBAD0_0000 | 32'(v.id));
    e.id     = v.id;
    e.status = v.status;
    e.data   = (v.op == 1'b1 && accepted) ? v.rdata : 32'h0;
    exp_q.push_back(e);
    wait_grant("vec_grant_seen", found);
    check("vec_grant_onehot", 32'(ob_ready), 32'd1 << v.id);
    req_valid  = '0;
    req_data   = {NREQ{32'h5555_AAAA}};
    core_full  = ~v.full;
    core_empty = ~v.empty;
    got = 1'b0; lat = 0; enqs = 0; deqs = 0; pulse_c = 0; wd = '0;
    for (int c = 1; c <= 24 && !got; c++) begin
      cyc();
      if (ob_enq) begin enqs++; pulse_c = c; wd = ob_wdata; end
      if (ob_deq) begin deqs++; pulse_c = c; end
      if (ob_rsp) begin got = 1'b1; lat = c; end
    end
    check("vec_rsp_seen", 32'(got), 32'd1);
    check("vec_latency", 32'(lat), accepted ? 32'(3 + v.k) : 32'd1);
    check("vec_enq_pulses", 32'(enqs), 32'(accepted && v.op == 1'b0));
    check("vec_deq_pulses", 32'(deqs), 32'(accepted && v.op == 1'b1));
    if (accepted) check("vec_pulse_cycle", 32'(pulse_c), 32'd1);
    if (accepted && v.op == 1'b0) check("vec_wdata", wd, v.data);
    check("vec_sb_empty", 32'(exp_q.size()), 32'd0);
    core_full  = 1'b0;
    core_empty = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    vec_t tbl[8];
    bit   found, got;
    int   pulses, rsps, ngr, lat;
    rsp_t e;

    tbl[0] = '{2'd2, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, 3, 32'h0,         ST_OK};
    tbl[1] = '{2'd1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, ST_OK};
    tbl[2] = '{2'd0, 1'b0, 32'h0000_0011, 1'b1, 1'b0, 0, 32'h0,         ST_FULL};
    tbl[3] = '{2'd3, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 0, 32'h0,         ST_EMPTY};
    tbl[4] = '{2'd0, 1'b0, 32'h0000_CAFE, 1'b0, 1'b1, 1, 32'h0,         ST_OK};
    tbl[5] = '{2'd2, 1'b1, 32'h0000_0033, 1'b1, 1'b0, 2, 32'h0000_0F0F, ST_OK};
    tbl[6] = '{2'd3, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 32'h0,         ST_OK};
    tbl[7] = '{2'd1, 1'b0, 32'h0000_0044, 1'b1, 1'b1, 0, 32'h0,         ST_FULL};

    rst = 1'b0;
    req_valid = '0; req_op = '0; req_data = '0;
    core_done = 1'b0; core_rdata = '0; core_full = 1'b0; core_empty = 1'b0;

    // Reset state
    repeat (3) cyc();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_core_pulses", 32'({core_enq, core_deq}), 32'd0);
    check("rst_core_wdata", core_wdata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fields", 32'({rsp_id, rsp_status}), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    rst = 1'b1;
    pulses = 0;
    repeat (20) begin
      cyc();
      if (ob_enq || ob_deq || ob_rsp) pulses++;
    end
    check("idle_no_activity", 32'(pulses), 32'd0);

    // All four requesters dequeue continuously
    auto_core = 1'b1; cur_k = 0;
    core_vals = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    for (int i = 0; i < 5; i++) begin
      e.id = 2'(i % 4); e.status = ST_OK; e.data = 32'h10 * 32'(i + 1);
      exp_q.push_back(e);
    end
    req_valid = 4'hF; req_op = 4'hF; req_data = {32'h4, 32'h3, 32'h2, 32'h1};
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 5; c++) begin
      cyc();
      if (ob_ready != '0) begin
        check("rr_grant_order", 32'(ob_ready), 32'd1 << (ngr % 4));
        ngr++;
      end
    end
    req_valid = '0;
    check("rr_grants_seen", 32'(ngr), 32'd5);
    repeat (8) cyc();
    check("rr_sb_drained", 32'(exp_q.size()), 32'd0);

    // Single-transaction table
    for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

    // Watchdog timeout, then a normal request
    auto_core = 1'b0;
    req_valid = 4'b0010; req_op = 4'b0000; req_data[1*W +: W] = 32'h77;
    e.id = 2'd1; e.status = ST_TIMEOUT; e.data = 32'h0;
    exp_q.push_back(e);
    wait_grant("to_grant_seen", found);
    req_valid = '0;
    got = 1'b0; lat = 0; pulses = 0;
    for (int c = 1; c <= 30 && !got; c++) begin
      cyc();
      if (ob_enq) pulses++;
      if (ob_rsp) begin got = 1'b1; lat = c; end
    end
    check("to_latency", 32'(lat), 32'(2 + TIMEOUT));
    check("to_enq_pulses", 32'(pulses), 32'd1);
    check("to_sb_empty", 32'(exp_q.size()), 32'd0);
    apply_vec('{2'd3, 1'b1, 32'h0, 1'b0, 1'b0, 1, 32'h0000_1234, ST_OK});

    // Reset during WAIT cycle 2 drops the request
    auto_core = 1'b0;
    req_valid = 4'b0100; req_op = 4'b0000; req_data[2*W +: W] = 32'h99;
    wait_grant("mr_grant_seen", found);
    req_valid = '0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("mr_async_outputs", 32'({core_enq, core_deq, rsp_valid}), 32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    core_done  = 1'b1;
    core_rdata = 32'h0000_0099;
    rsps = 0; pulses = 0;
    repeat (8) begin
      cyc();
      if (ob_rsp) rsps++;
      if (ob_enq || ob_deq) pulses++;
    end
    check("mr_no_response", 32'(rsps), 32'd0);
    check("mr_no_pulse", 32'(pulses), 32'd0);

    auto_core = 1'b1; cur_k = 0;
    core_vals.push_back(32'h5A5A_5A5A);
    e.id = 2'd0; e.status = ST_OK; e.data = 32'h5A5A_5A5A;
    exp_q.push_back(e);
    req_valid = 4'hF; req_op = 4'hF;
    wait_grant("mr_regrant_seen", found);
    check("mr_rr_ptr_reset", 32'(ob_ready), 32'd1);
    req_valid = '0;
    repeat (6) cyc();
    check("mr_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
